// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART decimal-command controller.
//   state_e     : controller state encoding
//   err_cause_e : error cause codes reported on err_cause
//   AsciiZero/AsciiNine : bounds of the accepted ASCII digit range
package uart_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StCollect = 2'b01,
    StCheck   = 2'b10,
    StHold    = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CauseOverrun = 2'b00,
    CauseBadChar = 2'b01,
    CauseTimeout = 2'b10,
    CauseRange   = 2'b11
  } err_cause_e;

  localparam logic [7:0] AsciiZero = 8'h30;
  localparam logic [7:0] AsciiNine = 8'h39;

  // A byte is usable only if it arrived without a parity error and is '0'..'9'.
  function automatic logic is_good_digit(input logic [7:0] b, input logic perr);
    return !perr && (b >= AsciiZero) && (b <= AsciiNine);
  endfunction

endpackage

// File: rtl/uart_edge_det.sv
// Rising-edge detector for the UART receiver done level.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_hecho    : receiver done level
//   o_hecho_q  : registered copy of i_hecho
//   o_event    : one-cycle byte event (i_hecho high, registered copy low)
module uart_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_hecho,
  output logic o_hecho_q,
  output logic o_event
);

  logic r_hecho;

  // Cleared in reset so a level already high afterwards counts as one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hecho <= 1'b0;
    end else begin
      r_hecho <= i_hecho;
    end
  end

  assign o_hecho_q = r_hecho;
  assign o_event   = i_hecho & ~r_hecho;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles NDIG ASCII decimal digits from a UART receiver into a binary command.
//   clk, rst_n          : clock, asynchronous active-low reset
//   dato, hecho, ERRrx  : received byte, done level, parity error
//   valor, cmd_valid    : checked command value and its valid flag
//   cmd_ready           : consumer accepts the held command
//   err, err_cause      : one-cycle error pulse and its cause
//   busy                : controller is not idle
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned NDIG    = 3,
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned MAXVAL  = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dato,
  input  logic       hecho,
  input  logic       ERRrx,
  output logic [9:0] valor,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       err,
  output logic [1:0] err_cause,
  output logic       busy
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e     r_state;
  err_cause_e r_err_cause;
  logic [9:0] r_acc;
  logic [1:0] r_cnt;
  logic [TW-1:0] r_timer;
  logic [9:0] r_valor;
  logic       r_cmd_valid;
  logic       r_err;

  logic       w_hecho_q;
  logic       w_event;
  logic       w_good;
  logic [3:0] w_digit;
  logic [9:0] w_acc_next;
  logic [1:0] w_cnt_next;

  uart_edge_det u_edge_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hecho  (hecho),
    .o_hecho_q(w_hecho_q),
    .o_event  (w_event)
  );

  assign w_good     = is_good_digit(dato, ERRrx);
  assign w_digit    = dato[3:0];
  assign w_acc_next = r_acc * 10'd10 + {6'd0, w_digit};
  assign w_cnt_next = r_cnt + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_err_cause <= CauseOverrun;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_valor     <= '0;
      r_cmd_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_event) begin
            if (w_good) begin
              r_acc   <= {6'd0, w_digit};
              r_cnt   <= 2'd1;
              r_timer <= '0;
              r_state <= (NDIG == 1) ? StCheck : StCollect;
            end else begin
              r_err       <= 1'b1;
              r_err_cause <= CauseBadChar;
              r_acc       <= '0;
              r_cnt       <= '0;
            end
          end
        end
        StCollect: begin
          // A byte event wins over a coincident timeout.
          if (w_event) begin
            if (w_good) begin
              r_acc   <= w_acc_next;
              r_cnt   <= w_cnt_next;
              r_timer <= '0;
              if (w_cnt_next == 2'(NDIG)) r_state <= StCheck;
            end else begin
              r_err       <= 1'b1;
              r_err_cause <= CauseBadChar;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_state     <= StIdle;
            end
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_err       <= 1'b1;
            r_err_cause <= CauseTimeout;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_state     <= StIdle;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        StCheck: begin
          if (r_acc > 10'(MAXVAL)) begin
            r_err       <= 1'b1;
            r_err_cause <= CauseRange;
            r_state     <= StIdle;
          end else begin
            r_valor     <= r_acc;
            r_cmd_valid <= 1'b1;
            r_state     <= StHold;
          end
          r_acc <= '0;
          r_cnt <= '0;
        end
        StHold: begin
          // Bytes arriving while a command is pending are dropped as overruns.
          if (w_event) begin
            r_err       <= 1'b1;
            r_err_cause <= CauseOverrun;
          end
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign valor     = r_valor;
  assign cmd_valid = r_cmd_valid;
  assign err       = r_err;
  assign err_cause = r_err_cause;
  assign busy      = (r_state != StIdle);

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter NDIG, default 3, number of ASCII decimal digits per command; legal range 1..3.
REQ-002 Parameter TIMEOUT, default 1000000, maximum clk cycles allowed between consecutive digits of one command.
REQ-003 Parameter MAXVAL, default 100, largest accepted command value; must be at most 999.
REQ-004 clk  in  1  system clock; all logic is on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 dato  in  8  received byte from the UART receiver; synchronous to clk.
REQ-007 hecho  in  1  receiver done level; synchronous to clk; one rising edge per received byte.
REQ-008 ERRrx  in  1  receiver parity error for the current byte; valid when hecho rises.
REQ-009 valor  out  10  assembled binary command value.
REQ-010 cmd_valid  out  1  valor holds a checked command.
REQ-011 cmd_ready  in  1  consumer accepts the command.
REQ-012 err  out  1  one-cycle error pulse.
REQ-013 err_cause  out  2  error cause, valid with err: 00 overrun, 01 bad character, 10 timeout, 11 out of range.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL register hecho every cycle; a byte event is hecho=1 while the registered copy is 0, giving one event per byte.
REQ-016 A byte is a good digit when ERRrx=0 and dato is in 0x30..0x39; its digit value is dato[3:0].
REQ-017 The state machine SHALL have the states IDLE, COLLECT, CHECK and HOLD.
REQ-018 IDLE: on a good digit, set acc=digit, cnt=1 and timer=0, then go to COLLECT; if NDIG=1, go directly to CHECK.
REQ-019 IDLE or COLLECT: on a bad byte, pulse err with cause 01, clear acc and cnt, and go to IDLE.
REQ-020 COLLECT: on a good digit, set acc=acc*10+digit, cnt=cnt+1 and timer=0; when the new cnt equals NDIG, go to CHECK.
REQ-021 COLLECT: with no byte event, timer increments; when timer reaches TIMEOUT-1, pulse err with cause 10 and go to IDLE.
REQ-022 COLLECT: when a byte event and the timeout occur in the same cycle, the byte event takes priority and no timeout is raised.
REQ-023 acc SHALL be 10 bits wide; 999 fits, so no overflow is possible.
REQ-024 CHECK lasts exactly one cycle.
REQ-025 CHECK: if acc>MAXVAL, pulse err with cause 11 and go to IDLE.
REQ-026 CHECK: otherwise, set valor=acc and cmd_valid=1, and go to HOLD.
REQ-027 Latency: cmd_valid SHALL rise 2 cycles after the byte event of the last digit.
REQ-028 HOLD: cmd_valid and valor SHALL stay stable until cmd_ready=1 is sampled.
REQ-029 HOLD: when cmd_ready=1 is sampled, clear cmd_valid and go to IDLE.
REQ-030 HOLD: a byte event is dropped and pulses err with cause 00.
REQ-031 HOLD: a byte event in the same cycle as cmd_ready is also dropped with cause 00.
REQ-032 cmd_ready is ignored outside HOLD.
REQ-033 valor SHALL keep the last accepted value until the next accepted command.
REQ-034 At most one err pulse SHALL occur per cycle.

Reset
REQ-035 While rst_n=0, all state and outputs SHALL be cleared asynchronously: state=IDLE, acc=0, cnt=0, timer=0, valor=0, cmd_valid=0, err=0, err_cause=00, busy=0, and the registered hecho=0.
REQ-036 Reset asserted mid-command SHALL discard the partial command with no err pulse.
REQ-037 After reset, a hecho level that is already high SHALL be taken as one byte event.

Structure
REQ-038 A shared package SHALL hold the state encoding, the err_cause codes and the ASCII digit bounds 0x30/0x39.
REQ-039 One sub-module, uart_edge_det, SHALL provide the registered hecho and the byte-event pulse.
REQ-040 The timer SHALL be sized to clog2(TIMEOUT).

Verification
REQ-041 Bytes "0","4","2" with cmd_ready held at 1 -> valor=42 and cmd_valid high for 1 cycle, 2 cycles after the third event; no err.
REQ-042 Bytes "1","5","0" -> err with cause 11; cmd_valid stays 0; valor keeps its previous value.
REQ-043 Bytes "0","7", then a gap of TIMEOUT cycles -> err with cause 10; state returns to IDLE; a following "0","0","9" gives valor=9.
REQ-044 Bytes "0", then 0x41, then "5" -> err with cause 01 on 0x41; "5" starts a new command with acc=5.
REQ-045 Command 055 held in HOLD with cmd_ready=0, plus one extra byte -> err with cause 00; valor stays 55; cmd_ready=1 then clears cmd_valid.
REQ-046 rst_n pulsed low after the second digit -> all outputs 0 with no err; the next full command assembles correctly.
